// File: rtl/sccb_target_pkg.sv
// Shared types and constants for the SCCB target: FSM state encoding,
// default device ID and bit-counter width.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_ACK,
    ST_IGNORE
  } sccb_state_t;

  localparam logic [7:0]  SCCB_DEFAULT_SID = 8'h60;
  localparam int unsigned BIT_CNT_W        = 3;

endpackage

// File: rtl/sccb_target_if.sv
// SCCB pad and register-port bundle; master = initiator/host side,
// slave = the sccb_target block.
interface sccb_target_if;
  logic       sioc;
  logic       siod_in;
  logic       siod_oe;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  modport master (
    output sioc, siod_in, rd_data,
    input  siod_oe, wr_valid, wr_addr, wr_data, rd_addr, busy
  );

  modport slave (
    input  sioc, siod_in, rd_data,
    output siod_oe, wr_valid, wr_addr, wr_data, rd_addr, busy
  );
endinterface

// File: rtl/sccb_sync_filter.sv
// Two-flop synchronizer followed by a level filter that accepts a change only
// after GLITCH_CYC consecutive equal samples; emits rise/fall strobes.
module sccb_sync_filter #(
  parameter int unsigned GLITCH_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int unsigned CW = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '1;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] != level) begin
        // cnt counts the differing samples already seen; this one completes the run
        if (cnt == CW'(GLITCH_CYC - 1)) begin
          level <= sync[1];
          cnt   <= '0;
          rise  <= sync[1];
          fall  <= ~sync[1];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/sccb_target.sv
// SCCB (3-wire/2-wire) register target with auto-incrementing subaddress.
// Read phases are built only when SCCB_TARGET_READ_EN is defined.
module sccb_target import sccb_pkg::*; #(
  parameter logic [7:0]  SID        = SCCB_DEFAULT_SID,
  parameter int unsigned GLITCH_CYC = 2
) (
  input logic          clk,
  input logic          rst_n,
  sccb_target_if.slave bus
);
  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  sccb_sync_filter #(.GLITCH_CYC(GLITCH_CYC)) u_sioc (
    .clk(clk), .rst_n(rst_n), .din(bus.sioc),
    .level(scl), .rise(scl_rise), .fall(scl_fall)
  );

  sccb_sync_filter #(.GLITCH_CYC(GLITCH_CYC)) u_siod (
    .clk(clk), .rst_n(rst_n), .din(bus.siod_in),
    .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  logic start, stop;
  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  sccb_state_t          state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [6:0]           rx;
  logic [1:0]           ack_ph;
  logic [7:0]           ptr;
  logic                 oe, wvalid, busy_r;
  logic [7:0]           waddr, wdata;
  logic [7:0]           byte_in;
  logic                 id_match;

  assign byte_in = {rx, sda};

`ifdef SCCB_TARGET_READ_EN
  logic       rd_req;
  logic [6:0] tx;
  assign id_match = (byte_in[7:1] == SID[7:1]);
`else
  logic unused_rd;
  assign unused_rd = ^bus.rd_data;
  assign id_match  = (byte_in[7:1] == SID[7:1]) && !byte_in[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      rx      <= '0;
      ack_ph  <= '0;
      ptr     <= '0;
      oe      <= 1'b0;
      wvalid  <= 1'b0;
      busy_r  <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
`ifdef SCCB_TARGET_READ_EN
      rd_req  <= 1'b0;
      tx      <= '0;
`endif
    end else begin
      wvalid <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        oe      <= 1'b0;
        busy_r  <= 1'b0;
        bit_cnt <= '0;
        ack_ph  <= '0;
      end else if (start) begin
        state   <= ST_ID;
        oe      <= 1'b0;
        busy_r  <= 1'b1;
        bit_cnt <= '0;
        ack_ph  <= '0;
      end else begin
        case (state)
          ST_ID: if (scl_rise) begin
            rx      <= byte_in[6:0];
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == '1) begin
              state  <= id_match ? ST_ID_ACK : ST_IGNORE;
              ack_ph <= '0;
`ifdef SCCB_TARGET_READ_EN
              rd_req <= byte_in[0];
`endif
            end
          end
          ST_ADDR: if (scl_rise) begin
            rx      <= byte_in[6:0];
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == '1) begin
              ptr    <= byte_in;
              state  <= ST_ADDR_ACK;
              ack_ph <= '0;
            end
          end
          ST_WDATA: if (scl_rise) begin
            rx      <= byte_in[6:0];
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == '1) begin
              wvalid <= 1'b1;
              waddr  <= ptr;
              wdata  <= byte_in;
              ptr    <= ptr + 8'd1;
              state  <= ST_WDATA_ACK;
              ack_ph <= '0;
            end
          end
          // First sioc fall starts the ack bit, the second one ends it
          ST_ID_ACK, ST_ADDR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (ack_ph == 2'd0) begin
              oe     <= 1'b1;
              ack_ph <= 2'd1;
            end else begin
              oe      <= 1'b0;
              ack_ph  <= '0;
              bit_cnt <= '0;
              if (state == ST_ID_ACK) begin
`ifdef SCCB_TARGET_READ_EN
                if (rd_req) begin
                  state <= ST_RDATA;
                  tx    <= bus.rd_data[6:0];
                  oe    <= ~bus.rd_data[7];
                end else begin
                  state <= ST_ADDR;
                end
`else
                state <= ST_ADDR;
`endif
              end else begin
                state <= ST_WDATA;
              end
            end
          end
`ifdef SCCB_TARGET_READ_EN
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              if (bit_cnt == '1) begin
                state  <= ST_RD_ACK;
                ack_ph <= '0;
              end
            end else if (scl_fall) begin
              oe <= ~tx[6];
              tx <= {tx[5:0], 1'b0};
            end
          end
          // Phases: release on fall, sample master ack on rise, reload on fall
          ST_RD_ACK: begin
            if (scl_fall && ack_ph == 2'd0) begin
              oe     <= 1'b0;
              ack_ph <= 2'd1;
            end else if (scl_rise && ack_ph == 2'd1) begin
              if (sda) begin
                state  <= ST_IGNORE;
                ack_ph <= '0;
              end else begin
                ptr    <= ptr + 8'd1;
                ack_ph <= 2'd2;
              end
            end else if (scl_fall && ack_ph == 2'd2) begin
              state   <= ST_RDATA;
              tx      <= bus.rd_data[6:0];
              oe      <= ~bus.rd_data[7];
              bit_cnt <= '0;
              ack_ph  <= '0;
            end
          end
`endif
          ST_IGNORE: oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign bus.siod_oe  = oe;
  assign bus.wr_valid = wvalid;
  assign bus.wr_addr  = waddr;
  assign bus.wr_data  = wdata;
  assign bus.rd_addr  = ptr;
  assign bus.busy     = busy_r;
endmodule

// File: tb/tb_sccb_target.sv
// Self-checking bench for sccb_target: bit-banged SCCB initiator, write
// scoreboard on wr_valid, direct checks of acks, read data and pointer.
`timescale 1ns/1ps
module tb_sccb_target;
  localparam int unsigned Q = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        master_sda;
  logic [7:0]  rd_val;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned oe_cycles = 0;
  logic [15:0] exp_q[$];

  sccb_target_if bus();

  sccb_target #(.SID(8'h60), .GLITCH_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #10 clk = ~clk;

  assign bus.siod_in = master_sda & ~bus.siod_oe;
  assign bus.rd_data = rd_val;

  always @(posedge clk) if (bus.siod_oe) oe_cycles <= oe_cycles + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : wr_monitor
    logic [15:0] e;
    if (rst_n && bus.wr_valid) begin
      if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr_data", {16'd0, bus.wr_addr, bus.wr_data}, {16'd0, e});
      end
    end
  end

  task automatic q_wait(input int unsigned n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic m_start();
    bus.sioc = 1'b1; master_sda = 1'b1; q_wait();
    master_sda = 1'b0; q_wait();
    bus.sioc = 1'b0; q_wait();
  endtask

  task automatic m_stop();
    master_sda = 1'b0; q_wait();
    bus.sioc = 1'b1; q_wait();
    master_sda = 1'b1; q_wait();
  endtask

  task automatic m_bit(input logic b);
    master_sda = b; q_wait();
    bus.sioc = 1'b1; q_wait(2);
    bus.sioc = 1'b0; q_wait();
  endtask

  task automatic m_write(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) m_bit(b[i]);
    master_sda = 1'b1; q_wait();
    bus.sioc = 1'b1; q_wait();
    ack = ~bus.siod_in; q_wait();
    bus.sioc = 1'b0; q_wait();
  endtask

  task automatic m_read(input logic nack, output logic [7:0] d);
    d = '0;
    master_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      q_wait(); bus.sioc = 1'b1;
      q_wait(); d[i] = bus.siod_in;
      q_wait(); bus.sioc = 1'b0;
    end
    m_bit(nack);
    master_sda = 1'b1;
  endtask

  task automatic wr_byte(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    m_write(b, a);
    check(tag, {31'd0, a}, {31'd0, exp_ack});
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : main
    logic [7:0]  d;
    int unsigned oe0;
    rst_n = 1'b0; bus.sioc = 1'b1; master_sda = 1'b1; rd_val = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_oe",      {31'd0, bus.siod_oe},  0);
    check("rst_wvalid",  {31'd0, bus.wr_valid}, 0);
    check("rst_busy",    {31'd0, bus.busy},     0);
    check("rst_rd_addr", {24'd0, bus.rd_addr},  0);
    check("rst_wr_addr", {24'd0, bus.wr_addr},  0);
    check("rst_wr_data", {24'd0, bus.wr_data},  0);
    rst_n = 1'b1; q_wait(2);

    // 3-phase write 60/FF/80
    m_start();
    wr_byte("w1_ack_id", 8'h60, 1'b1);
    check("w1_busy", {31'd0, bus.busy}, 1);
    wr_byte("w1_ack_addr", 8'hFF, 1'b1);
    exp_q.push_back({8'hFF, 8'h80});
    wr_byte("w1_ack_data", 8'h80, 1'b1);
    m_stop();
    check("w1_busy_idle", {31'd0, bus.busy}, 0);
    check("w1_ptr", {24'd0, bus.rd_addr}, 32'h00);

    // burst with pointer wrap
    m_start();
    wr_byte("w2_ack_id", 8'h60, 1'b1);
    wr_byte("w2_ack_addr", 8'hFF, 1'b1);
    exp_q.push_back({8'hFF, 8'h01});
    wr_byte("w2_ack_d0", 8'h01, 1'b1);
    exp_q.push_back({8'h00, 8'h02});
    wr_byte("w2_ack_d1", 8'h02, 1'b1);
    m_stop();
    check("w2_ptr", {24'd0, bus.rd_addr}, 32'h01);

    // foreign ID is ignored
    oe0 = oe_cycles;
    m_start();
    wr_byte("w3_nack_id", 8'h42, 1'b0);
    wr_byte("w3_nack_b1", 8'h12, 1'b0);
    wr_byte("w3_nack_b2", 8'h34, 1'b0);
    check("w3_no_oe", oe_cycles - oe0, 0);
    check("w3_busy_ignore", {31'd0, bus.busy}, 1);
    m_stop();
    check("w3_busy_idle", {31'd0, bus.busy}, 0);
    check("w3_ptr_kept", {24'd0, bus.rd_addr}, 32'h01);

    // set pointer then read
    m_start();
    wr_byte("r_ack_id", 8'h60, 1'b1);
    wr_byte("r_ack_addr", 8'h0A, 1'b1);
    m_stop();
    check("r_ptr_set", {24'd0, bus.rd_addr}, 32'h0A);
    m_start();
`ifdef SCCB_TARGET_READ_EN
    wr_byte("r_ack_rid", 8'h61, 1'b1);
    m_read(1'b0, d);
    check("r_data0", {24'd0, d}, 32'hA5);
    check("r_ptr_inc", {24'd0, bus.rd_addr}, 32'h0B);
    m_read(1'b1, d);
    check("r_data1", {24'd0, d}, 32'hA5);
    m_stop();
    check("r_ptr_end", {24'd0, bus.rd_addr}, 32'h0B);
`else
    wr_byte("r_nack_rid", 8'h61, 1'b0);
    m_stop();
    check("r_ptr_end", {24'd0, bus.rd_addr}, 32'h0A);
`endif
    check("r_busy_idle", {31'd0, bus.busy}, 0);

    // reset in the middle of a data byte
    m_start();
    wr_byte("x_ack_id", 8'h60, 1'b1);
    wr_byte("x_ack_addr", 8'h01, 1'b1);
    for (int i = 0; i < 4; i++) m_bit(i[0]);
    rst_n = 1'b0;
    #1;
    check("x_rst_oe",      {31'd0, bus.siod_oe},  0);
    check("x_rst_busy",    {31'd0, bus.busy},     0);
    check("x_rst_rd_addr", {24'd0, bus.rd_addr},  0);
    check("x_rst_wr_data", {24'd0, bus.wr_data},  0);
    check("x_rst_wr_addr", {24'd0, bus.wr_addr},  0);
    bus.sioc = 1'b1; master_sda = 1'b1;
    q_wait();
    rst_n = 1'b1; q_wait(2);
    m_start();
    wr_byte("x2_ack_id", 8'h60, 1'b1);
    wr_byte("x2_ack_addr", 8'h01, 1'b1);
    exp_q.push_back({8'h01, 8'h02});
    wr_byte("x2_ack_data", 8'h02, 1'b1);
    m_stop();
    check("x2_ptr", {24'd0, bus.rd_addr}, 32'h02);

    // one-clock siod glitches while sioc is high
    bus.sioc = 1'b1; master_sda = 1'b1; q_wait();
    master_sda = 1'b0; @(negedge clk); master_sda = 1'b1;
    q_wait(2);
    check("g_no_start", {31'd0, bus.busy}, 0);
    m_start();
    wr_byte("g_ack_id", 8'h60, 1'b1);
    master_sda = 1'b0; q_wait();
    bus.sioc = 1'b1; q_wait();
    master_sda = 1'b1; @(negedge clk); master_sda = 1'b0;
    q_wait();
    check("g_no_stop", {31'd0, bus.busy}, 1);
    bus.sioc = 1'b0; q_wait();
    m_stop();
    check("g_busy_idle", {31'd0, bus.busy}, 0);
    check("g_ptr", {24'd0, bus.rd_addr}, 32'h02);

    q_wait(2);
    check("wr_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sccb_target.md
SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 Parameter SID, default 8'h60: 7-bit write device ID in [7:1]; bit 0 is ignored on compare.
REQ-002 Parameter GLITCH_CYC, default 2: consecutive equal synchronized samples needed to accept a sioc/siod level change.
REQ-003 clk  input  1  system clock (50 MHz), the block's only clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sioc  input  1  SCCB clock from the initiator.
REQ-006 siod_in  input  1  SCCB data as sampled from the pad.
REQ-007 siod_oe  output  1  1 = pull siod low (open-drain). The pad never drives high.
REQ-008 wr_valid  output  1  one-clk pulse: register write completed.
REQ-009 wr_addr  output  8  subaddress for the write; valid with wr_valid.
REQ-010 wr_data  output  8  data for the write; valid with wr_valid.
REQ-011 rd_addr  output  8  current subaddress pointer.
REQ-012 rd_data  input  8  register contents at rd_addr; sampled once per read byte.
REQ-013 busy  output  1  high from accepted START until STOP or return to IDLE.

Function
REQ-014 sioc and siod_in each pass through a 2-flop synchronizer and a GLITCH_CYC filter; all decoding uses the filtered levels.
REQ-015 START is a filtered siod fall while sioc is high. STOP is a filtered siod rise while sioc is high.
REQ-016 Data bits are sampled on the filtered sioc rise, MSB first. siod_oe changes only on the filtered sioc fall.
REQ-017 FSM states: IDLE, ID, ID_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE. A 3-bit bit counter runs in ID/ADDR/WDATA/RDATA.
REQ-018 IDLE -> ID on START.
REQ-019 ID -> ID_ACK after 8 bits when byte[7:1] == SID[7:1]; on mismatch -> IGNORE.
REQ-020 ID_ACK: drive siod_oe=1 for one sioc period. Next state: ADDR if bit0=0, RDATA if bit0=1.
REQ-021 ADDR -> ADDR_ACK (ack driven). The byte loads the rd_addr pointer; next state WDATA.
REQ-022 WDATA -> WDATA_ACK (ack driven). Pulse wr_valid 1 clk with wr_addr=pointer and wr_data=byte, then pointer +1 mod 256 and return to WDATA for burst writes.
REQ-023 RDATA: rd_data is latched at ACK-phase end. Shift it out MSB first: siod_oe = ~bit. In RD_ACK release siod and sample the master bit. 0 = continue (pointer +1, wrapping 8'hFF -> 8'h00); 1 = NACK -> IGNORE.
REQ-024 IGNORE: siod_oe=0. Only START/STOP are decoded.
REQ-025 Repeated START in any state -> ID with the bit counter cleared; the pointer is kept.
REQ-026 STOP in any state -> IDLE with siod_oe=0. A partial byte is discarded and produces no wr_valid.
REQ-027 START and STOP take precedence over a bit sample in the same clk.
REQ-028 SCCB 3-phase write (ID, addr, data + STOP) yields exactly one wr_valid.

Reset
REQ-029 With rst_n=0, immediately: siod_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, FSM=IDLE, synchronizers and filters loaded with 1.
REQ-030 Reset mid-transaction abandons it; no wr_valid is issued.

Configuration
REQ-031 Macro SCCB_TARGET_READ_EN defined: read phases per REQ-020/REQ-023.
REQ-032 Macro undefined: an ID with bit0=1 is not acknowledged, the FSM goes to IGNORE, RDATA/RD_ACK logic is absent, and rd_data is unused.

Structure
REQ-033 Package sccb_pkg holds: the state enum, the default SID constant 8'h60, and the bit-counter width.
REQ-034 One sub-module, sccb_sync_filter (synchronizer, glitch filter, rise/fall strobes), instantiated once for sioc and once for siod_in.

Verification
REQ-035 Write 60/FF/80 + STOP -> three acks, then one wr_valid with wr_addr=FF, wr_data=80.
REQ-036 Burst 60/FF/01/02 -> wr_valid (FF,01) then (00,02); pointer wraps.
REQ-037 ID 42/12/34 -> no ack, siod_oe stays 0, no wr_valid, then IDLE on STOP.
REQ-038 READ_EN, rd_data=A5: 60/0A STOP, 61 -> siod shows A5 and rd_addr=0A. With the macro off: 61 is NACKed.
REQ-039 rst_n low during WDATA bit 4 -> outputs at reset values; next 60/01/02 -> wr_valid (01,02).
REQ-040 1-clk siod glitch while sioc is high -> no START/STOP detected.
